misao_mem_bridge: RTL and testbench

MISAO_MEM_BRIDGE -- requirements
Module: misao_mem_bridge

---
 rtl/misao_mem_bridge.sv | 138 +++++++++++++
 tb/tb_misao_mem_bridge.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/misao_mem_bridge.sv
// Core-to-bus bridge: one outstanding byte read or write, with a timeout abort and a sticky error flag.
// Optional one-entry last-read cache, enabled by defining MISAO_BRIDGE_RDCACHE_EN.
module misao_mem_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_en_read,
  input  logic        core_en_write,
  input  logic [14:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic [7:0]  core_rdata,
  output logic        core_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [14:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam int ADDR_W = 15;
  localparam int DATA_W = 8;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t              state_q;
  state_t              state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [7:0]          cnt_q;
  logic [DATA_W-1:0]   rd_q;
  logic                err_q;

  logic                cache_hit;
  logic                accept;
  logic                both_en;
  logic                in_bus;
  logic                tmo;
  logic                gnt_fire;
  logic                rv_fire;
  logic                abort;

  assign both_en  = core_en_read & core_en_write;
  assign accept   = (state_q == IDLE) & (core_en_read | core_en_write) & ~cache_hit;
  assign in_bus   = (state_q == REQ) | (state_q == WAIT_R);
  // The counter shows the number of cycles already spent, so TMO_LAST marks the final allowed cycle.
  assign tmo      = in_bus & (cnt_q == TMO_LAST);
  assign gnt_fire = (state_q == REQ) & mem_gnt;
  assign rv_fire  = (state_q == WAIT_R) & mem_rvalid;
  assign abort    = ((state_q == REQ) & ~mem_gnt & tmo) | ((state_q == WAIT_R) & ~mem_rvalid & tmo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = REQ;
      REQ: begin
        if (mem_gnt)  state_d = we_q ? DONE : WAIT_R;
        else if (tmo) state_d = DONE;
      end
      WAIT_R:  if (mem_rvalid || tmo) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == REQ);
    core_stall = in_bus | accept;
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign bus_err   = err_q;

  // Request latches, timeout counter, read register and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      cnt_q   <= 8'd0;
      rd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= core_addr;
        wdata_q <= core_wdata;
        we_q    <= core_en_write;
      end
      if (accept || (gnt_fire && !we_q)) cnt_q <= 8'd0;
      else if (in_bus)                   cnt_q <= cnt_q + 8'd1;
      if (rv_fire)    rd_q <= mem_rdata;
      else if (abort) rd_q <= 8'hFF;
      if ((accept && both_en) || abort) err_q <= 1'b1;
    end
  end

`ifdef MISAO_BRIDGE_RDCACHE_EN
  logic              c_vld_q;
  logic [ADDR_W-1:0] c_tag_q;
  logic [DATA_W-1:0] c_data_q;

  // A write in the same cycle as a read is treated as a write, so it never hits.
  assign cache_hit  = (state_q == IDLE) & core_en_read & ~core_en_write & c_vld_q & (c_tag_q == core_addr);
  assign core_rdata = cache_hit ? c_data_q : rd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_vld_q  <= 1'b0;
      c_tag_q  <= '0;
      c_data_q <= '0;
    end else if (rv_fire) begin
      c_vld_q  <= 1'b1;
      c_tag_q  <= addr_q;
      c_data_q <= mem_rdata;
    end else if (gnt_fire && we_q && c_vld_q && (c_tag_q == addr_q)) begin
      c_data_q <= wdata_q;
    end else if (abort && !we_q) begin
      c_vld_q  <= 1'b0;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign core_rdata = rd_q;
`endif

endmodule

// File: tb/tb_misao_mem_bridge.sv
// Self-checking bench for misao_mem_bridge: directed cases plus randomized transactions against a transaction-level model.
module tb_misao_mem_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_en_read, core_en_write;
  logic [14:0] core_addr;
  logic [7:0]  core_wdata;
  logic [7:0]  core_rdata;
  logic        core_stall;
  logic        mem_req, mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt, mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        bus_err;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_rd;
  logic        exp_err;
  logic        m_vld;
  logic [14:0] m_tag;
  logic [7:0]  m_data;

  misao_mem_bridge #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .core_en_read(core_en_read), .core_en_write(core_en_write),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cycle();
    core_en_read = 1'b0; core_en_write = 1'b0;
    #1;
    chk("idle_stall", core_stall, 1'b0);
    chk("idle_req", mem_req, 1'b0);
    chk("idle_rdata", core_rdata, exp_rd);
    chk("idle_err", bus_err, exp_err);
    tick();
  endtask

  // One core transaction: gd = REQ cycles without grant before mem_gnt, rdl = WAIT_R cycles before mem_rvalid.
  task automatic txn(input logic wr, input logic rd, input logic [14:0] a, input logic [7:0] wd,
                     input int gd, input int rdl, input logic [7:0] bd, input logic stray);
    logic is_read;
    logic abort;
    int   n_req;
    int   n_wait;
    is_read = rd & ~wr;
`ifdef MISAO_BRIDGE_RDCACHE_EN
    if (is_read && m_vld && m_tag == a) begin
      core_en_read = 1'b1; core_en_write = 1'b0; core_addr = a;
      #1;
      chk("hit_stall", core_stall, 1'b0);
      chk("hit_req", mem_req, 1'b0);
      chk("hit_rdata", core_rdata, m_data);
      tick();
      core_en_read = 1'b0;
      return;
    end
`endif
    abort = 1'b0;
    n_wait = 0;
    if (gd >= T) begin
      n_req = T; abort = 1'b1;
    end else begin
      n_req = gd + 1;
      if (is_read) begin
        if (rdl >= T) begin n_wait = T; abort = 1'b1; end
        else n_wait = rdl + 1;
      end
    end
    core_en_read = rd; core_en_write = wr; core_addr = a; core_wdata = wd;
    #1;
    chk("accept_stall", core_stall, 1'b1);
    chk("accept_req", mem_req, 1'b0);
    tick();
    core_en_read = 1'b0; core_en_write = 1'b0;
    core_addr = 15'($urandom); core_wdata = 8'($urandom);
    for (int i = 1; i <= n_req + n_wait; i++) begin
      mem_gnt    = (i == gd + 1);
      mem_rvalid = (i == n_req + 1 + rdl) || (stray && i <= n_req);
      mem_rdata  = (i <= n_req) ? ~bd : bd;
      #1;
      chk("busy_stall", core_stall, 1'b1);
      chk("busy_req", mem_req, (i <= n_req));
      if (i <= n_req) begin
        chk("mem_we", mem_we, wr);
        chk("mem_addr", mem_addr, a);
        chk("mem_wdata", mem_wdata, wd);
      end
      tick();
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
    if (wr && rd) exp_err = 1'b1;
    if (abort) begin
      exp_err = 1'b1;
      exp_rd  = 8'hFF;
      if (is_read) m_vld = 1'b0;
    end else if (is_read) begin
      exp_rd = bd;
      m_vld = 1'b1; m_tag = a; m_data = bd;
    end else if (m_vld && m_tag == a) begin
      m_data = wd;
    end
    #1;
    chk("done_stall", core_stall, 1'b0);
    chk("done_req", mem_req, 1'b0);
    chk("done_rdata", core_rdata, exp_rd);
    chk("done_err", bus_err, exp_err);
    tick();
  endtask

  initial begin
    rst = 1'b0;
    core_en_read = 1'b0; core_en_write = 1'b0; core_addr = '0; core_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    exp_rd = 8'h00; exp_err = 1'b0; m_vld = 1'b0; m_tag = '0; m_data = '0;
    tick(); tick();
    #1;
    chk("rst_rdata", core_rdata, 8'h00);
    chk("rst_stall", core_stall, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 15'h0);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_err", bus_err, 1'b0);
    rst = 1'b1;

    // First request right after release; minimum-latency read.
    txn(1'b0, 1'b1, 15'h0005, 8'h00, 0, 0, 8'hA3, 1'b0);
    idle_cycle();
    // Write with grant held off for 4 cycles.
    txn(1'b1, 1'b0, 15'h0010, 8'h5C, 4, 0, 8'h00, 1'b0);
    // Grant and rvalid on the very last allowed cycle.
    txn(1'b0, 1'b1, 15'h0033, 8'h00, T - 1, T - 1, 8'h3C, 1'b1);
    chk("no_err_yet", bus_err, 1'b0);
    // Both enables: write wins, error set.
    txn(1'b1, 1'b1, 15'h0020, 8'h77, 1, 0, 8'h00, 1'b0);
    // Grant never comes: abort after T REQ cycles, then error stays through 3 transactions.
    txn(1'b0, 1'b1, 15'h0044, 8'h00, T, 0, 8'h00, 1'b0);
    txn(1'b0, 1'b1, 15'h0045, 8'h00, 0, 1, 8'h12, 1'b0);
    txn(1'b1, 1'b0, 15'h0046, 8'h34, 2, 0, 8'h00, 1'b0);
    txn(1'b0, 1'b1, 15'h0047, 8'h00, 1, 2, 8'h56, 1'b0);
    // rvalid never comes: abort from WAIT_R.
    txn(1'b0, 1'b1, 15'h0048, 8'h00, 0, T, 8'h00, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic wr, rd;
      wr = 1'($urandom);
      rd = wr ? ($urandom_range(0, 3) == 0) : 1'b1;
      txn(wr, rd, 15'($urandom_range(0, 7)), 8'($urandom), $urandom_range(0, T),
          $urandom_range(0, T), 8'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset in the middle of a read waiting for data.
    core_en_read = 1'b1; core_addr = 15'h0099;
    tick();
    core_en_read = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    #1;
    chk("pre_rst_stall", core_stall, 1'b1);
    rst = 1'b0;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_stall", core_stall, 1'b0);
    chk("arst_rdata", core_rdata, 8'h00);
    chk("arst_err", bus_err, 1'b0);
    tick();
    #1;
    mem_rvalid = 1'b1; mem_rdata = 8'hEE;
    #1;
    chk("rst_hold_req", mem_req, 1'b0);
    chk("rst_hold_stall", core_stall, 1'b0);
    mem_rvalid = 1'b0;
    rst = 1'b1;
    exp_rd = 8'h00; exp_err = 1'b0; m_vld = 1'b0;
    txn(1'b0, 1'b1, 15'h0099, 8'h00, 0, 0, 8'h6B, 1'b0);
    idle_cycle();

`ifdef MISAO_BRIDGE_RDCACHE_EN
    txn(1'b0, 1'b1, 15'h0007, 8'h00, 0, 0, 8'h11, 1'b0);
    txn(1'b1, 1'b0, 15'h0007, 8'h22, 0, 0, 8'h00, 1'b0);
    core_en_read = 1'b1; core_addr = 15'h0007;
    #1;
    chk("cache_stall", core_stall, 1'b0);
    chk("cache_req", mem_req, 1'b0);
    chk("cache_rdata", core_rdata, 8'h22);
    tick();
    core_en_read = 1'b0;
    idle_cycle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
